// File: rtl/lane_onehot_sequencer.sv
// -----------------------------------------------------------------------------
// lane_onehot_sequencer
//
// Purpose:
//   Decoder-direction companion to the GPPCU priority encoder. A command
//   (start lane, lane count, lane-enable mask) is accepted in IDLE. The block
//   then sweeps upward from the start lane, wrapping from IBW-1 to 0. It
//   emits one registered one-hot lane select per enabled lane. Disabled lanes
//   cost one scan cycle each. Every emitted beat is followed by a one-cycle
//   bubble.
//
// Ports:
//   CLK        in   1        clock, rising edge
//   RSTn       in   1        asynchronous active-low reset
//   IN_VALID   in   1        command valid
//   IN_READY   out  1        command accept; high only in IDLE (low on DONE)
//   IN_INDEX   in   EBW      start lane
//   IN_COUNT   in   EBW+1    lanes to traverse; values above IBW clamp to IBW
//   IN_MASK    in   IBW      lane enable; 0 = lane skipped
//   OUT_VALID  out  1        OUT_SEL valid
//   OUT_READY  in   1        downstream accept
//   OUT_SEL    out  IBW      one-hot lane select (registered)
//   OUT_INDEX  out  EBW      binary index of the lane in OUT_SEL
//   OUT_LAST   out  1        final emitted beat of a command
//   DONE       out  1        one-cycle pulse when a command completes
//   BUSY       out  1        high whenever the state is not IDLE
// -----------------------------------------------------------------------------
module lane_onehot_sequencer #(
    parameter  int EBW = 4,
    localparam int IBW = 1 << EBW
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [EBW-1:0]   IN_INDEX,
    input  logic [EBW:0]     IN_COUNT,
    input  logic [IBW-1:0]   IN_MASK,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [IBW-1:0]   OUT_SEL,
    output logic [EBW-1:0]   OUT_INDEX,
    output logic             OUT_LAST,
    output logic             DONE,
    output logic             BUSY
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_EMIT = 2'd2
    } state_t;

    // Lane count expressed in the width of the remaining-count register.
    localparam logic [EBW:0] L_IBW_CNT = (EBW+1)'(IBW);

    // One-hot decode of a lane index.
    function automatic logic [IBW-1:0] f_onehot(input logic [EBW-1:0] idx);
        logic [IBW-1:0] v;
        v = {{(IBW-1){1'b0}}, 1'b1} << idx;
        return v;
    endfunction

    // True when none of the rem-1 lanes following cur (with wrap) is enabled.
    // The mask is doubled so a plain right shift performs the rotation; a
    // window of rem-1 low bits then selects the lanes still to be visited.
    function automatic logic f_is_last(input logic [IBW-1:0] mask,
                                       input logic [EBW-1:0] cur,
                                       input logic [EBW:0]   rem);
        logic [2*IBW-1:0] dbl;
        logic [EBW:0]     shamt;
        logic [IBW:0]     win;
        logic [IBW-1:0]   rot;
        dbl   = {mask, mask};
        shamt = {1'b0, cur} + {{EBW{1'b0}}, 1'b1};
        dbl   = dbl >> shamt;
        rot   = dbl[IBW-1:0];
        win   = ({{IBW{1'b0}}, 1'b1} << (rem - {{EBW{1'b0}}, 1'b1}))
              - {{IBW{1'b0}}, 1'b1};
        return ((rot & win[IBW-1:0]) == {IBW{1'b0}});
    endfunction

    state_t           r_state,     w_state_nxt;
    logic [EBW-1:0]   r_cursor,    w_cursor_nxt;
    logic [EBW:0]     r_rem,       w_rem_nxt;
    logic [IBW-1:0]   r_mask,      w_mask_nxt;
    logic             r_out_valid, w_out_valid_nxt;
    logic [IBW-1:0]   r_out_sel,   w_out_sel_nxt;
    logic [EBW-1:0]   r_out_index, w_out_index_nxt;
    logic             r_out_last,  w_out_last_nxt;
    logic             r_done,      w_done_nxt;
    logic             r_busy,      w_busy_nxt;
    logic             r_in_ready,  w_in_ready_nxt;

    logic [EBW-1:0]   w_cursor_inc;
    logic [EBW:0]     w_rem_dec;
    logic [EBW:0]     w_count_clamped;
    logic             w_lane_en;
    logic             w_last_pre;
    logic             w_accept;
    logic             w_out_hs;

    assign w_cursor_inc    = r_cursor + {{(EBW-1){1'b0}}, 1'b1};
    assign w_rem_dec       = r_rem - {{EBW{1'b0}}, 1'b1};
    assign w_count_clamped = (IN_COUNT > L_IBW_CNT) ? L_IBW_CNT : IN_COUNT;
    assign w_lane_en       = r_mask[r_cursor];
    assign w_last_pre      = f_is_last(r_mask, r_cursor, r_rem);
    assign w_accept        = IN_VALID & r_in_ready;
    assign w_out_hs        = r_out_valid & OUT_READY;

    // Next-state and next-output logic for the IDLE/SCAN/EMIT sequencer.
    always_comb begin
        w_state_nxt     = r_state;
        w_cursor_nxt    = r_cursor;
        w_rem_nxt       = r_rem;
        w_mask_nxt      = r_mask;
        w_out_valid_nxt = r_out_valid;
        w_out_sel_nxt   = r_out_sel;
        w_out_index_nxt = r_out_index;
        w_out_last_nxt  = r_out_last;
        w_done_nxt      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_cursor_nxt = IN_INDEX;
                    w_rem_nxt    = w_count_clamped;
                    w_mask_nxt   = IN_MASK;
                    if (w_count_clamped == {(EBW+1){1'b0}}) begin
                        // Empty command completes without leaving IDLE.
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_SCAN;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end

            ST_SCAN: begin
                if (w_lane_en) begin
                    w_out_valid_nxt = 1'b1;
                    w_out_sel_nxt   = f_onehot(r_cursor);
                    w_out_index_nxt = r_cursor;
                    w_out_last_nxt  = w_last_pre;
                    w_state_nxt     = ST_EMIT;
                end else begin
                    w_cursor_nxt = w_cursor_inc;
                    w_rem_nxt    = w_rem_dec;
                    if (w_rem_dec == {(EBW+1){1'b0}}) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_SCAN;
                    end
                end
            end

            ST_EMIT: begin
                if (w_out_hs) begin
                    w_cursor_nxt    = w_cursor_inc;
                    w_rem_nxt       = w_rem_dec;
                    w_out_valid_nxt = 1'b0;
                    if (r_out_last || (w_rem_dec == {(EBW+1){1'b0}})) begin
                        // Trailing disabled lanes are skipped, not scanned.
                        w_out_sel_nxt  = {IBW{1'b0}};
                        w_out_last_nxt = 1'b0;
                        w_done_nxt     = 1'b1;
                        w_state_nxt    = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_SCAN;
                    end
                end else begin
                    w_state_nxt = ST_EMIT;
                end
            end

            default: begin
                // Unreachable encoding: recover to a clean idle state.
                w_state_nxt     = ST_IDLE;
                w_cursor_nxt    = {EBW{1'b0}};
                w_rem_nxt       = {(EBW+1){1'b0}};
                w_mask_nxt      = {IBW{1'b0}};
                w_out_valid_nxt = 1'b0;
                w_out_sel_nxt   = {IBW{1'b0}};
                w_out_index_nxt = {EBW{1'b0}};
                w_out_last_nxt  = 1'b0;
            end
        endcase

        // Status outputs are registered from the next state so they line up
        // with it; IN_READY stays low through the DONE cycle.
        w_busy_nxt     = (w_state_nxt != ST_IDLE);
        w_in_ready_nxt = (w_state_nxt == ST_IDLE) && !w_done_nxt;
    end

    // State, datapath and output registers with asynchronous reset.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state     <= ST_IDLE;
            r_cursor    <= {EBW{1'b0}};
            r_rem       <= {(EBW+1){1'b0}};
            r_mask      <= {IBW{1'b0}};
            r_out_valid <= 1'b0;
            r_out_sel   <= {IBW{1'b0}};
            r_out_index <= {EBW{1'b0}};
            r_out_last  <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_cursor    <= w_cursor_nxt;
            r_rem       <= w_rem_nxt;
            r_mask      <= w_mask_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_sel   <= w_out_sel_nxt;
            r_out_index <= w_out_index_nxt;
            r_out_last  <= w_out_last_nxt;
            r_done      <= w_done_nxt;
            r_busy      <= w_busy_nxt;
            r_in_ready  <= w_in_ready_nxt;
        end
    end

    assign IN_READY  = r_in_ready;
    assign OUT_VALID = r_out_valid;
    assign OUT_SEL   = r_out_sel;
    assign OUT_INDEX = r_out_index;
    assign OUT_LAST  = r_out_last;
    assign DONE      = r_done;
    assign BUSY      = r_busy;

endmodule
